// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared types and helpers for the FIFO read-side drain engine.
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } fifo_rd_state_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready output stream carrying data words and a packet-end marker.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );

endinterface

// File: rtl/fifo_rd_stream_out_reg.sv
// stream_out_reg: output stage of the drain engine. Holds one word with its last flag and
// presents it as a valid/ready beat. A load always wins; otherwise an accepted beat empties it.
module stream_out_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  // Load a new beat, or drop valid once the current beat has been accepted.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a show-ahead FIFO into a valid/ready stream and groups the words
// into packets of BURST_LEN beats marked with m_tlast.
// Optional feature macro FIFO_RD_STREAM_TIMEOUT_EN: when defined, a partial packet is closed
// after the FIFO has stayed empty for TIMEOUT cycles. When undefined, packets are always
// exactly BURST_LEN words and TIMEOUT is only range-checked.
//
// Each word waits in a hold register until the engine knows whether it closes the packet:
// either a successor word is visible in the FIFO, or it is the BURST_LEN-th beat, or
// (with the timeout feature) the FIFO stayed empty long enough.
//
// state    | meaning
// ST_IDLE  | hold register empty
// ST_HOLD  | hold register valid, not yet known whether its word is last
// ST_FLUSH | FIFO empty for TIMEOUT cycles, held word committed as last
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                reset_p,
  input  logic [WIDTH-1:0]    fifo_data_i,
  input  logic                fifo_empty_i,
  output logic                fifo_rd_o,
  fifo_rd_stream_if.master    m
);

  localparam int BW = cnt_width(BURST_LEN);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

  if (BURST_LEN < 2 || TIMEOUT < 1) begin : g_param_check
    $error("fifo_rd_stream: BURST_LEN must be >= 2 and TIMEOUT >= 1");
  end

  fifo_rd_state_t  state;
  logic [WIDTH-1:0] h_data;
  logic [BW-1:0]    beat_cnt;

  logic o_free;
  logic last_beat;
  logic move;
  logic load_last;

`ifdef FIFO_RD_STREAM_TIMEOUT_EN
  localparam int IW = cnt_width(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_SAT  = IW'(TIMEOUT);

  logic [IW-1:0] idle_cnt;
`endif

  assign o_free    = ~m.m_tvalid | m.m_tready;
  assign last_beat = (beat_cnt == BEAT_LAST);

  // The held word may leave once its fate is known: a successor is visible, it fills the
  // packet, or the FIFO has been empty long enough to flush it as a short packet.
`ifdef FIFO_RD_STREAM_TIMEOUT_EN
  assign move      = o_free & (((state == ST_HOLD) & (~fifo_empty_i | last_beat)) |
                               (state == ST_FLUSH));
  assign load_last = last_beat | (state == ST_FLUSH);
`else
  assign move      = o_free & (state == ST_HOLD) & (~fifo_empty_i | last_beat);
  assign load_last = last_beat;
`endif

  // Pop whenever the hold register is empty or is being vacated this cycle.
  assign fifo_rd_o = ~reset_p & ~fifo_empty_i & ((state == ST_IDLE) | move);

  // Hold-register FSM with beat and idle counters.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state    <= ST_IDLE;
      h_data   <= '0;
      beat_cnt <= '0;
`ifdef FIFO_RD_STREAM_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      if (move) begin
        beat_cnt <= load_last ? '0 : beat_cnt + 1'b1;
      end

      if ((state == ST_IDLE) || move) begin
        if (fifo_rd_o) begin
          state  <= ST_HOLD;
          h_data <= fifo_data_i;
`ifdef FIFO_RD_STREAM_TIMEOUT_EN
          idle_cnt <= '0;
`endif
        end else begin
          state <= ST_IDLE;
        end
      end
`ifdef FIFO_RD_STREAM_TIMEOUT_EN
      // A flush already decided is never revoked; only an empty FIFO advances the timer.
      else if ((state == ST_HOLD) && fifo_empty_i) begin
        if (idle_cnt != IDLE_SAT) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
        if (idle_cnt == IDLE_LAST) begin
          state <= ST_FLUSH;
        end
      end
`endif
    end
  end

  stream_out_reg #(
    .WIDTH (WIDTH)
  ) u_out (
    .clk       (clk),
    .reset_p   (reset_p),
    .load      (move),
    .load_data (h_data),
    .load_last (load_last),
    .ready     (m.m_tready),
    .valid     (m.m_tvalid),
    .data      (m.m_tdata),
    .last      (m.m_tlast)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: show-ahead FIFO model driving fifo_rd_stream, with an expected-beat
// queue filled as words are pushed and drained on every stream handshake.
module tb_fifo_rd_stream;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_p;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;

  logic [15:0] fifo_q[$];
  beat_t       exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_pop, last_pop, first_hs, last_hs, hs_cnt;

  logic        prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;

  fifo_rd_stream_if #(.WIDTH(16)) s_if ();

  fifo_rd_stream #(
    .WIDTH     (16),
    .BURST_LEN (4),
    .TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .reset_p      (reset_p),
    .fifo_data_i  (fifo_data),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_o    (fifo_rd),
    .m            (s_if)
  );

  always #5 clk = ~clk;

  task automatic fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 16'h0000 : fifo_q[0];
  endtask

  task automatic push_word(input logic [15:0] w, input logic l);
    beat_t b;
    b.data = w;
    b.last = l;
    fifo_q.push_back(w);
    exp_q.push_back(b);
    fifo_refresh();
  endtask

  task automatic clear_track();
    first_pop = -1;
    last_pop  = -1;
    first_hs  = -1;
    last_hs   = -1;
    hs_cnt    = 0;
  endtask

  // One clock cycle, entered and left at the falling edge. Inputs set by the caller before
  // the call are observed, the handshake is scored, then the FIFO model applies the pop.
  task automatic step();
    logic        pop, hs, v, l;
    logic [15:0] d;
    beat_t       e;
    #1;
    pop = fifo_rd;
    v   = s_if.m_tvalid;
    d   = s_if.m_tdata;
    l   = s_if.m_tlast;
    hs  = v & s_if.m_tready & ~reset_p;
    if (prev_stall) begin
      checks++;
      if (v !== 1'b1 || d !== prev_data || l !== prev_last) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                 cyc, v, d, l, prev_data, prev_last);
      end
    end
    prev_stall = v & ~s_if.m_tready & ~reset_p;
    prev_data  = d;
    prev_last  = l;
    if (pop === 1'b1) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (hs === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat cyc=%0d: got unexpected beat d=%h l=%b, required no beat", cyc, d, l);
      end else begin
        e = exp_q.pop_front();
        if (d !== e.data || l !== e.last) begin
          failures++;
          $display("FAIL beat cyc=%0d: got d=%h l=%b, required d=%h l=%b",
                   cyc, d, l, e.data, e.last);
        end
      end
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      hs_cnt++;
    end
    @(posedge clk);
    #1;
    if (pop === 1'b1 && fifo_q.size() != 0) fifo_q.delete(0);
    fifo_refresh();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_drained(input string name, input int want_hs);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (hs_cnt != want_hs) begin
      failures++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, hs_cnt, want_hs);
    end
  endtask

  task automatic test_reset();
    reset_p       = 1'b1;
    s_if.m_tready = 1'b1;
    prev_stall    = 1'b0;
    fifo_q.delete();
    fifo_q.push_back(16'h0001);
    fifo_refresh();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({fifo_rd, s_if.m_tvalid, s_if.m_tlast} !== 3'b000) begin
        failures++;
        $display("FAIL reset_ctrl: got rd/valid/last=%b%b%b, required 000",
                 fifo_rd, s_if.m_tvalid, s_if.m_tlast);
      end
      checks++;
      if (s_if.m_tdata !== 16'h0000) begin
        failures++;
        $display("FAIL reset_data: got %h, required 0000", s_if.m_tdata);
      end
    end
    fifo_q.delete();
    fifo_refresh();
    @(negedge clk);
    reset_p = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_track();
    s_if.m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(16'(i), (i % 4) == 0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    repeat (4) step();
    check_drained("b2b", 8);
    checks++;
    if (first_hs - first_pop != 2) begin
      failures++;
      $display("FAIL b2b_latency: got %0d cycles, required 2", first_hs - first_pop);
    end
    checks++;
    if (last_hs - first_hs != 7) begin
      failures++;
      $display("FAIL b2b_rate: got span %0d cycles, required 7", last_hs - first_hs);
    end
  endtask

  task automatic test_timeout();
    clear_track();
    s_if.m_tready = 1'b1;
`ifdef FIFO_RD_STREAM_TIMEOUT_EN
    push_word(16'hABCD, 1'b1);
    for (int i = 0; i < 30; i++) step();
    check_drained("timeout", 1);
    checks++;
    if (last_hs - first_pop != 10) begin
      failures++;
      $display("FAIL timeout_latency: got %0d cycles, required 10", last_hs - first_pop);
    end
`else
    push_word(16'hABCD, 1'b0);
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (hs_cnt != 0) begin
      failures++;
      $display("FAIL no_timeout_hold: got %0d beats, required 0", hs_cnt);
    end
    push_word(16'hABCE, 1'b0);
    push_word(16'hABCF, 1'b0);
    push_word(16'hABD0, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    repeat (4) step();
    check_drained("no_timeout", 4);
`endif
  endtask

  task automatic test_stall();
    int n;
    clear_track();
    s_if.m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
`ifdef FIFO_RD_STREAM_TIMEOUT_EN
      push_word(16'h0010 + 16'(i), (i == 3) || (i == 5));
`else
      push_word(16'h0010 + 16'(i), i == 3);
`endif
    end
`ifdef FIFO_RD_STREAM_TIMEOUT_EN
    n = 6;
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      s_if.m_tready = ~s_if.m_tready;
      step();
    end
`else
    n = 8;
    for (int i = 0; i < 30; i++) begin
      s_if.m_tready = ~s_if.m_tready;
      step();
    end
    checks++;
    if (hs_cnt != 5) begin
      failures++;
      $display("FAIL stall_partial: got %0d beats, required 5", hs_cnt);
    end
    push_word(16'h0016, 1'b0);
    push_word(16'h0017, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      s_if.m_tready = ~s_if.m_tready;
      step();
    end
`endif
    s_if.m_tready = 1'b1;
    repeat (4) step();
    check_drained("stall", n);
  endtask

`ifdef FIFO_RD_STREAM_TIMEOUT_EN
  task automatic test_flush_arrival();
    clear_track();
    s_if.m_tready = 1'b0;
    push_word(16'h0100, 1'b1);
    for (int i = 0; i < 5 && first_pop < 0; i++) step();
    for (int i = 0; i < 20 && cyc < first_pop + 9; i++) step();
    push_word(16'h0101, 1'b0);
    step();
    checks++;
    if (last_pop != first_pop + 9) begin
      failures++;
      $display("FAIL flush_pop: got pop at +%0d, required +9", last_pop - first_pop);
    end
    push_word(16'h0102, 1'b0);
    push_word(16'h0103, 1'b0);
    push_word(16'h0104, 1'b1);
    repeat (3) step();
    s_if.m_tready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    repeat (4) step();
    check_drained("flush_arrival", 5);
  endtask
`endif

  task automatic test_reset_mid();
    clear_track();
    s_if.m_tready = 1'b1;
    fifo_q.push_back(16'h0302);
    fifo_q.push_back(16'h0303);
    fifo_q.push_back(16'h0304);
    fifo_q.push_front(16'h0301);
    exp_q.push_back({16'h0300, 1'b0});
    exp_q.push_back({16'h0301, 1'b0});
    fifo_q.push_front(16'h0300);
    fifo_refresh();
    for (int i = 0; i < 20 && hs_cnt < 2; i++) step();
    s_if.m_tready = 1'b0;
    reset_p = 1'b1;
    fifo_q.delete();
    fifo_refresh();
    step();
    reset_p    = 1'b0;
    prev_stall = 1'b0;
    checks++;
    if (s_if.m_tvalid !== 1'b0 || s_if.m_tlast !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_out: got valid=%b last=%b, required 0 0",
               s_if.m_tvalid, s_if.m_tlast);
    end
    s_if.m_tready = 1'b1;
    push_word(16'h0200, 1'b0);
    push_word(16'h0201, 1'b0);
    push_word(16'h0202, 1'b0);
    push_word(16'h0203, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    repeat (4) step();
    check_drained("mid_reset", 6);
  endtask

  initial begin
    fifo_refresh();
    test_reset();
    test_back_to_back();
    test_timeout();
    test_stall();
`ifdef FIFO_RD_STREAM_TIMEOUT_EN
    test_flush_arrival();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for a show-ahead FIFO with `data_o`/`data_rd`/`empty` semantics. It pops words and presents them as a valid/ready stream, and groups them into packets with `m_tlast`. A packet closes after `BURST_LEN` words, or early when the FIFO stays empty for `TIMEOUT` cycles. It sits between a FIFO and a downstream stream consumer such as a DMA, serializer or host bridge.

## Interface
- `WIDTH`, default 16: data word width.
- `BURST_LEN`, default 8: words per full packet, ≥2.
- `TIMEOUT`, default 16: consecutive FIFO-empty cycles before a partial packet is closed, ≥1.
- `clk` in 1: clock; the only clock.
- `reset_p` in 1: reset, synchronous and active-high.
- `fifo_data_i` in `WIDTH`: FIFO head word; valid whenever `fifo_empty_i` = 0.
- `fifo_empty_i` in 1: FIFO empty.
- `fifo_rd_o` out 1: pop strobe; one word is popped per cycle with `fifo_rd_o` = 1.
- `m_tdata` out `WIDTH`: stream data.
- `m_tvalid` out 1: stream valid.
- `m_tlast` out 1: last word of packet.
- `m_tready` in 1: consumer ready.

## Operation
- Two storage stages:
  - Hold register H: data and valid.
  - Output register O: data, valid, last; drives `m_*`.
- FSM on H:
  - `ST_IDLE`: H empty.
  - `ST_HOLD`: H valid; waiting to learn whether its word is last.
  - `ST_FLUSH`: timeout reached; H is committed as last.
- `o_free` = ~O.valid | m_tready.
- move (H→O):
  - In `ST_HOLD`: o_free & (~fifo_empty_i | beat_cnt==BURST_LEN-1).
  - In `ST_FLUSH`: o_free.
- `fifo_rd_o` = ~reset_p & ~fifo_empty_i & (state==`ST_IDLE` | move).
  - Combinational from `m_tready`; accepted.
- On move:
  - O.data ← H.data.
  - O.last ← (beat_cnt==BURST_LEN-1) | (state==`ST_FLUSH`).
  - beat_cnt ← O.last ? 0 : beat_cnt+1.
- After move or in `ST_IDLE`:
  - Pop → `ST_HOLD`, H ← `fifo_data_i`, idle_cnt ← 0.
  - No pop → `ST_IDLE`.
- `ST_HOLD` without move, FIFO empty:
  - idle_cnt increments.
  - When idle_cnt==TIMEOUT-1, go to `ST_FLUSH`.
- `ST_HOLD` without move, FIFO non-empty: not possible, because a non-empty FIFO implies move whenever o_free. Otherwise hold; idle_cnt is not incremented.
- A word arriving while in `ST_FLUSH` does not cancel the flush. The flushed word keeps last=1 and the new word starts beat 0.
- O is cleared (O.valid ← 0) when m_tready & ~move.
- Counter widths:
  - beat_cnt: $clog2(BURST_LEN).
  - idle_cnt: $clog2(TIMEOUT+1).
  - idle_cnt saturates and never wraps.

## Timing
- Reset values: `fifo_rd_o`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0. Internally state=`ST_IDLE`, beat_cnt=0, idle_cnt=0.
- Reset mid-packet discards H and O contents. The next packet starts at beat 0. Words already popped are lost; this is by design.
- Streaming latency: pop at cycle t → H at t+1 → O (`m_tvalid`) at t+2, provided a next word exists or the word is the BURST_LEN-th.
- Throughput: 1 word/cycle sustained while `m_tready`=1 and the FIFO is non-empty.
- Timeout latency: lone word popped at t (FIFO empty from t+1):
  - `ST_FLUSH` at t+TIMEOUT+1.
  - `m_tvalid`/`m_tlast` = 1 at t+TIMEOUT+2 if O is free.
- Stream rule: `m_tdata`/`m_tlast` are stable while `m_tvalid` & ~`m_tready`. `m_tvalid` never drops without a handshake.

## Configuration
- `FIFO_RD_STREAM_TIMEOUT_EN` defined: timeout flush as described above.
- Not defined:
  - `ST_FLUSH` and idle_cnt are removed.
  - Packets are always exactly `BURST_LEN` words.
  - A word stays in H until its successor arrives or it is the BURST_LEN-th word.
  - `TIMEOUT` is ignored.

## Structure
- Package `fifo_rd_stream_pkg`:
  - state enum `fifo_rd_state_t` (`ST_IDLE`, `ST_HOLD`, `ST_FLUSH`).
  - localparam helper for counter widths.
- Sub-module `stream_out_reg`: the O stage (data/valid/last register with load and handshake-clear). Instantiated once.

## Test plan
Bench parameters: WIDTH=16, BURST_LEN=4, TIMEOUT=8, FIFO modelled as show-ahead.
1. FIFO holds 0x0001; reset_p=1 for 3 cycles → `fifo_rd_o`=0, `m_tvalid`=0, `m_tlast`=0 throughout.
2. FIFO preloaded with 0x0001..0x0008, `m_tready`=1 → 8 back-to-back beats starting 2 cycles after the first pop; `m_tlast`=1 only on 0x0004 and 0x0008.
3. Single word 0xABCD popped at t, FIFO then empty → 0xABCD with `m_tlast`=1 at t+10; nothing else is emitted.
4. 6 words 0x0010..0x0015, `m_tready` toggling 1/0 each cycle → no loss or duplication, outputs stable while stalled; tlast on 0x0013 (length) and 0x0015 (timeout).
5. Lone word 0x0100 reaches `ST_FLUSH` with `m_tready`=0; 0x0101 is pushed that cycle → 0x0100 is emitted with tlast=1, 0x0101 starts a new packet at beat 0.
6. reset_p pulsed after 2 beats of a packet; then 0x0200..0x0203 are pushed → tlast on 0x0203 (full 4-beat packet).
7. Repeat 2 and 3 with `FIFO_RD_STREAM_TIMEOUT_EN` undefined → 3 emits nothing until 3 more words arrive, then emits a 4-beat packet.
